alu_status_unit: RTL and testbench

ALU_STATUS_UNIT -- requirements
Module: alu_status_unit

---
 rtl/alu_status_unit.sv | 133 +++++++++++++
 tb/tb_alu_status_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_status_unit.sv
// ALU status flag register {N,Z,C,V} with a single-cycle condition evaluator.
// Defining ALU_STATUS_STICKY_EN adds a sticky overflow bit and a saturating overflow counter.
module alu_status_unit #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             setflags_i,
  input  logic [2:0]       opcode_i,
  input  logic [N-1:0]     result_i,
  input  logic             overflow_i,
  input  logic             cout_i,
  input  logic             check_i,
  input  logic [3:0]       cond_i,
  input  logic             clear_i,
  output logic [3:0]       flags_o,
  output logic             cond_valid_o,
`ifdef ALU_STATUS_STICKY_EN
  output logic             ovf_sticky_o,
  output logic [CNT_W-1:0] ovf_count_o,
`endif
  output logic             cond_pass_o
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMov = 3'b100;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [3:0] r_flags;
  logic       r_cond_valid;
  logic       r_cond_pass;
  logic [3:0] w_flags_nxt;
  logic       w_upd;
  logic       w_zero;
  logic       w_pass;

  assign w_upd  = valid_i & setflags_i;
  assign w_zero = (result_i == '0);

  // Condition is evaluated against w_flags_nxt so a same-cycle update is bypassed.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = ~z;
      4'b0010: eval_cond = cy;
      4'b0011: eval_cond = ~cy;
      4'b0100: eval_cond = n;
      4'b0101: eval_cond = ~n;
      4'b0110: eval_cond = v;
      4'b0111: eval_cond = ~v;
      4'b1000: eval_cond = cy & ~z;
      4'b1001: eval_cond = ~cy | z;
      4'b1010: eval_cond = (n == v);
      4'b1011: eval_cond = (n != v);
      4'b1100: eval_cond = ~z & (n == v);
      4'b1101: eval_cond = z | (n != v);
      4'b1110: eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  always_comb begin
    w_flags_nxt = r_flags;
    if (clear_i) begin
      w_flags_nxt = 4'b0000;
    end else if (w_upd) begin
      case (opcode_i)
        OpAdd, OpSub: w_flags_nxt = {result_i[N-1], w_zero, cout_i, overflow_i};
        OpMov:        w_flags_nxt = {result_i[N-1], w_zero, r_flags[1:0]};
        default:      w_flags_nxt = r_flags;
      endcase
    end
  end

  assign w_pass = eval_cond(cond_i, w_flags_nxt);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_flags      <= 4'b0000;
      r_cond_valid <= 1'b0;
      r_cond_pass  <= 1'b0;
    end else begin
      r_flags      <= w_flags_nxt;
      r_cond_valid <= check_i;
      if (check_i) begin
        r_cond_pass <= w_pass;
      end
    end
  end

  assign flags_o      = r_flags;
  assign cond_valid_o = r_cond_valid;
  assign cond_pass_o  = r_cond_pass;

`ifdef ALU_STATUS_STICKY_EN
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_ovf_count;
  logic             w_ovf_evt;

  // Overflow events count independently of setflags_i; clear wins over a same-cycle event.
  assign w_ovf_evt = valid_i & overflow_i & ((opcode_i == OpAdd) | (opcode_i == OpSub));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (clear_i) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (w_ovf_evt) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_count != {CNT_W{1'b1}}) begin
        r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ovf_sticky_o = r_ovf_sticky;
  assign ovf_count_o  = r_ovf_count;
`endif

endmodule

// File: tb/tb_alu_status_unit.sv
// Table-driven bench for alu_status_unit; expected outputs are queued at drive time and
// popped after each edge. Sticky/counter checks are included when ALU_STATUS_STICKY_EN is set.
module tb_alu_status_unit;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 2;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic       setf;
    logic [2:0] op;
    logic [3:0] res;
    logic       ovf;
    logic       cout;
    logic       chk;
    logic [3:0] cond;
    logic       clr;
    logic [3:0] e_flags;
    logic       e_cv;
    logic       e_pass;
    logic       stk_chk;
    logic       e_stk;
    logic [1:0] e_cnt;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             valid;
  logic             setf;
  logic [2:0]       op;
  logic [N-1:0]     res;
  logic             ovf;
  logic             cout;
  logic             chk;
  logic [3:0]       cond;
  logic             clr;
  logic [3:0]       flags;
  logic             cond_valid;
  logic             cond_pass;
`ifdef ALU_STATUS_STICKY_EN
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
`endif

  int   n_pass;
  int   n_total;
  vec_t exp_q[$];
  vec_t tbl[$];

  alu_status_unit #(
    .N    (N),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid),
    .setflags_i  (setf),
    .opcode_i    (op),
    .result_i    (res),
    .overflow_i  (ovf),
    .cout_i      (cout),
    .check_i     (chk),
    .cond_i      (cond),
    .clear_i     (clr),
    .flags_o     (flags),
    .cond_valid_o(cond_valid),
`ifdef ALU_STATUS_STICKY_EN
    .ovf_sticky_o(ovf_sticky),
    .ovf_count_o (ovf_count),
`endif
    .cond_pass_o (cond_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic s, input logic [2:0] o,
                              input logic [3:0] rs, input logic ov, input logic co,
                              input logic ck, input logic [3:0] cd, input logic cl,
                              input logic [3:0] ef, input logic ecv, input logic ep);
    vec_t t;
    t.rst_n = r;   t.valid = v;  t.setf = s;  t.op = o;   t.res = rs;
    t.ovf = ov;    t.cout = co;  t.chk = ck;  t.cond = cd; t.clr = cl;
    t.e_flags = ef; t.e_cv = ecv; t.e_pass = ep;
    t.stk_chk = 1'b0; t.e_stk = 1'b0; t.e_cnt = 2'd0;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic step(input vec_t t);
    vec_t e;
    rst_n = t.rst_n; valid = t.valid; setf = t.setf; op = t.op; res = t.res;
    ovf = t.ovf; cout = t.cout; chk = t.chk; cond = t.cond; clr = t.clr;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("flags", {28'd0, flags}, {28'd0, e.e_flags});
    check("cond_valid", {31'd0, cond_valid}, {31'd0, e.e_cv});
    check("cond_pass", {31'd0, cond_pass}, {31'd0, e.e_pass});
`ifdef ALU_STATUS_STICKY_EN
    if (e.stk_chk) begin
      check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, e.e_stk});
      check("ovf_count", {30'd0, ovf_count}, {30'd0, e.e_cnt});
    end
`endif
  endtask

  initial begin
    vec_t t;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0; valid = 1'b0; setf = 1'b0; op = 3'b000; res = '0;
    ovf = 1'b0; cout = 1'b0; chk = 1'b0; cond = 4'b0000; clr = 1'b0;
    @(negedge clk);

    //            r  v  s  op      res      ov co ck cond     cl flags    cv p
    tbl.push_back(mk(0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 1, 1, 3'b000, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0110, 0, 0));
    tbl.push_back(mk(1, 1, 1, 3'b001, 4'b1000, 1, 0, 1, 4'b1010, 0, 4'b1001, 1, 1));
    tbl.push_back(mk(1, 0, 1, 3'b000, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b1001, 0, 1));
    tbl.push_back(mk(1, 1, 1, 3'b001, 4'b0001, 1, 1, 0, 4'b0000, 0, 4'b0011, 0, 1));
    tbl.push_back(mk(1, 1, 1, 3'b100, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0111, 0, 1));
    tbl.push_back(mk(1, 1, 0, 3'b000, 4'b1111, 0, 0, 1, 4'b0000, 0, 4'b0111, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b1111, 0, 4'b0111, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b1110, 0, 4'b0111, 1, 1));
    tbl.push_back(mk(1, 1, 1, 3'b010, 4'b1000, 0, 0, 1, 4'b0011, 0, 4'b0111, 1, 0));
    tbl.push_back(mk(1, 0, 1, 3'b000, 4'b0000, 0, 0, 1, 4'b1001, 0, 4'b0111, 1, 1));
    tbl.push_back(mk(1, 1, 1, 3'b000, 4'b1000, 1, 1, 1, 4'b0101, 1, 4'b0000, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 1, 3'b000, 4'b0100, 1, 0, 1, 4'b1011, 0, 4'b0001, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b1100, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b1101, 0, 4'b0001, 1, 1));
    tbl.push_back(mk(1, 1, 1, 3'b000, 4'b1100, 0, 1, 1, 4'b0100, 0, 4'b1010, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b0110, 0, 4'b1010, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b0111, 0, 4'b1010, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b0010, 0, 4'b1010, 1, 1));
    tbl.push_back(mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 1, 4'b0001, 0, 4'b1010, 1, 1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

`ifdef ALU_STATUS_STICKY_EN
    // Clear, then five overflowing adds without setflags: counter saturates at 3.
    t = mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 1);
    t.stk_chk = 1'b1; t.e_stk = 1'b0; t.e_cnt = 2'd0;
    step(t);
    for (int k = 1; k <= 5; k++) begin
      t = mk(1, 1, 0, 3'b000, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1);
      t.stk_chk = 1'b1; t.e_stk = 1'b1; t.e_cnt = (k >= 3) ? 2'd3 : 2'(k);
      step(t);
    end
    t = mk(1, 1, 1, 3'b001, 4'b1000, 1, 0, 0, 4'b0000, 1, 4'b0000, 0, 1);
    t.stk_chk = 1'b1; t.e_stk = 1'b0; t.e_cnt = 2'd0;
    step(t);
    // Mov with overflow and an invalid add must not count.
    t = mk(1, 1, 0, 3'b100, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1);
    t.stk_chk = 1'b1; t.e_stk = 1'b0; t.e_cnt = 2'd0;
    step(t);
    t = mk(1, 0, 0, 3'b000, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1);
    t.stk_chk = 1'b1; t.e_stk = 1'b0; t.e_cnt = 2'd0;
    step(t);
    t = mk(1, 1, 0, 3'b001, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1);
    t.stk_chk = 1'b1; t.e_stk = 1'b1; t.e_cnt = 2'd1;
    step(t);
`endif

    // Load non-zero state, then reset with update and check pending: no pulse follows.
    step(mk(1, 1, 1, 3'b000, 4'b1000, 1, 1, 1, 4'b1110, 0, 4'b1011, 1, 1));
    t = mk(0, 1, 1, 3'b000, 4'b1000, 1, 1, 1, 4'b1110, 0, 4'b0000, 0, 0);
    t.stk_chk = 1'b1;
    step(t);
    t = mk(1, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    t.stk_chk = 1'b1;
    step(t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
